// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states,
// flag-bus bit positions and opcode decode helpers.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_DEC = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  // Bit positions on the ALU flag bus {sh_r, sh_l, mov, inc, dec, or, and, sub, add}
  localparam logic [3:0] FLG_ADD = 4'd0;
  localparam logic [3:0] FLG_SUB = 4'd1;
  localparam logic [3:0] FLG_AND = 4'd2;
  localparam logic [3:0] FLG_OR  = 4'd3;
  localparam logic [3:0] FLG_DEC = 4'd4;
  localparam logic [3:0] FLG_INC = 4'd5;
  localparam logic [3:0] FLG_MOV = 4'd6;
  localparam logic [3:0] FLG_SHL = 4'd7;
  localparam logic [3:0] FLG_SHR = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Opcodes outside 1..9 select undriven ALU mux inputs.
  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_DEC) && (op <= OP_SHR);
  endfunction

  function automatic logic [3:0] flag_idx(input logic [3:0] op);
    case (op)
      OP_DEC:  return FLG_DEC;
      OP_ADD:  return FLG_ADD;
      OP_SUB:  return FLG_SUB;
      OP_AND:  return FLG_AND;
      OP_OR:   return FLG_OR;
      OP_MOV:  return FLG_MOV;
      OP_INC:  return FLG_INC;
      OP_SHL:  return FLG_SHL;
      OP_SHR:  return FLG_SHR;
      default: return FLG_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Operand register file: two combinational read ports, one synchronous
// write port, all entries cleared by reset.
module alu_regfile #(
  parameter int REG_AW = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Reset has priority so a write pending in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit gate-level ALU: accepts one instruction,
// drives registered ALU inputs, writes the result back and returns a response.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int REG_AW = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_load,
  input  logic [3:0]        instr_op,
  input  logic [1:0]        instr_fsel,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_c,
  output logic [1:0]        alu_d,
  output logic              alu_e,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [8:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_flag,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // instr_ready and rsp_valid depend only on the FSM state; the response
  // payload is held stable while rsp_valid is high and not yet accepted.

  state_e            state_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_c_q;
  logic [1:0]        alu_d_q;
  logic              alu_e_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_flag_q, rsp_err_q;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              accept;

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

  // Loads write at accept; ALU results write at the end of EXEC.
  assign rf_we    = (state_q == EXEC) || (accept && instr_load);
  assign rf_waddr = (state_q == EXEC) ? rd_q : instr_rd;
  assign rf_wdata = (state_q == EXEC) ? alu_out : instr_imm;

  alu_regfile #(
    .REG_AW (REG_AW),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (instr_rs1),
    .rdata_a_o (rs1_data),
    .raddr_b_i (instr_rs2),
    .rdata_b_o (rs2_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_c_q    <= '0;
      alu_d_q    <= '0;
      alu_e_q    <= 1'b0;
      rd_q       <= '0;
      rsp_data_q <= '0;
      rsp_flag_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (instr_load) begin
              rsp_data_q <= instr_imm;
              rsp_flag_q <= 1'b0;
              rsp_err_q  <= 1'b0;
              state_q    <= RESP;
            end else if (op_legal(instr_op)) begin
              alu_a_q <= rs1_data;
              alu_b_q <= rs2_data;
              alu_c_q <= instr_op;
              alu_d_q <= instr_fsel;
              alu_e_q <= instr_fsel[0];
              rd_q    <= instr_rd;
              state_q <= EXEC;
            end else begin
              rsp_data_q <= '0;
              rsp_flag_q <= 1'b0;
              rsp_err_q  <= 1'b1;
              state_q    <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_data_q <= alu_out;
          rsp_flag_q <= alu_flags[flag_idx(alu_c_q)];
          rsp_err_q  <= 1'b0;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_d     = alu_d_q;
  assign alu_e     = alu_e_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random instructions,
// checked against a register-file/ALU reference model kept in the bench.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready, instr_load;
  logic [3:0] instr_op;
  logic [1:0] instr_fsel;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_c;
  logic [1:0] alu_d;
  logic       alu_e;
  logic [7:0] alu_out;
  logic [8:0] alu_flags;
  logic       rsp_valid, rsp_ready, rsp_flag, rsp_err;
  logic [7:0] rsp_data;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] regs_m [4];
  logic [7:0] am, bm;
  logic [3:0] cm;
  logic [1:0] dm;
  logic       em;
  logic [8:0] flags_v;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_load(instr_load),
    .instr_op(instr_op), .instr_fsel(instr_fsel), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d), .alu_e(alu_e),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Behaviour of the external ALU, also used as the reference arithmetic.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    return a - 8'd1;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a;
      4'd7:    return a + 8'd1;
      4'd8:    return {a[6:0], 1'b0};
      4'd9:    return {1'b0, a[7:1]};
      default: return 8'h00;
    endcase
  endfunction

  function automatic int flag_pos(input logic [3:0] op);
    case (op)
      4'd1: return 4;
      4'd2: return 0;
      4'd3: return 1;
      4'd4: return 2;
      4'd5: return 3;
      4'd6: return 6;
      4'd7: return 5;
      4'd8: return 7;
      default: return 8;
    endcase
  endfunction

  assign alu_out   = alu_fn(alu_c, alu_a, alu_b);
  assign alu_flags = flags_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) regs_m[i] = 8'h00;
    am = 0; bm = 0; cm = 0; dm = 0; em = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_instr_ready", instr_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_flag", rsp_flag, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_abc", {alu_a, alu_b, alu_c}, 0);
    check("rst_alu_de", {alu_d, alu_e}, 0);
    rst = 1'b0;
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic run_instr(input bit load, input logic [3:0] op, input logic [1:0] fsel,
                           input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [7:0] imm, input int hold);
    logic [7:0] e_data;
    logic       e_flag, e_err;
    bit         legal;
    legal = (op >= 4'd1) && (op <= 4'd9);
    check("idle_instr_ready", instr_ready, 1);
    instr_valid = 1'b1; instr_load = load; instr_op = op; instr_fsel = fsel;
    instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    flags_v = 9'($urandom_range(0, 511));
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (load) begin
      e_data = imm; e_flag = 1'b0; e_err = 1'b0;
      regs_m[rd] = imm;
    end else if (legal) begin
      @(negedge clk);
      check("exec_alu_a", alu_a, regs_m[rs1]);
      check("exec_alu_b", alu_b, regs_m[rs2]);
      check("exec_alu_c", alu_c, op);
      check("exec_alu_d", alu_d, fsel);
      check("exec_alu_e", alu_e, fsel[0]);
      check("exec_rsp_valid", rsp_valid, 0);
      check("exec_instr_ready", instr_ready, 0);
      e_data = alu_fn(op, regs_m[rs1], regs_m[rs2]);
      e_flag = flags_v[flag_pos(op)];
      e_err  = 1'b0;
      am = regs_m[rs1]; bm = regs_m[rs2]; cm = op; dm = fsel; em = fsel[0];
      regs_m[rd] = e_data;
    end else begin
      e_data = 8'h00; e_flag = 1'b0; e_err = 1'b1;
    end
    @(negedge clk);
    check("resp_valid", rsp_valid, 1);
    check("resp_data", rsp_data, e_data);
    check("resp_flag", rsp_flag, e_flag);
    check("resp_err", rsp_err, e_err);
    check("resp_instr_ready", instr_ready, 0);
    check("resp_alu_hold", {alu_a, alu_b, alu_c, alu_d, alu_e}, {am, bm, cm, dm, em});
    // Offer a competing load while the response waits; it must not be taken.
    for (int i = 0; i < hold; i++) begin
      instr_valid = 1'b1; instr_load = 1'b1; instr_rd = rd; instr_imm = 8'hEE;
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_payload", {rsp_data, rsp_flag, rsp_err}, {e_data, e_flag, e_err});
      check("stall_instr_ready", instr_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_instr_ready", instr_ready, 1);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 0; instr_load = 0; instr_op = 0; instr_fsel = 0;
    instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0; instr_imm = 0; rsp_ready = 0;
    flags_v = 0;
    model_reset();
    do_reset();

    // ADD after two loads, then MOV reads R2 back through alu_a.
    run_instr(1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'h05, 0);
    run_instr(1, 4'd0, 2'd0, 2'd1, 2'd0, 2'd0, 8'h03, 0);
    run_instr(0, 4'd2, 2'd1, 2'd2, 2'd0, 2'd1, 8'h00, 0);
    check("add_result_r2", regs_m[2], 8'h08);
    run_instr(0, 4'd6, 2'd2, 2'd3, 2'd2, 2'd0, 8'h00, 1);

    // SUB of equal operands.
    run_instr(1, 4'd0, 2'd0, 2'd1, 2'd0, 2'd0, 8'h05, 0);
    run_instr(0, 4'd3, 2'd0, 2'd3, 2'd0, 2'd1, 8'h00, 0);

    // Illegal opcodes, one with a long response stall.
    run_instr(0, 4'd0, 2'd3, 2'd1, 2'd2, 2'd3, 8'h00, 0);
    run_instr(0, 4'd12, 2'd1, 2'd2, 2'd0, 2'd1, 8'h00, 5);

    // SHL in place with rd == rs1.
    run_instr(1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'h81, 0);
    run_instr(0, 4'd8, 2'd3, 2'd0, 2'd0, 2'd0, 8'h00, 2);
    run_instr(0, 4'd6, 2'd0, 2'd1, 2'd0, 2'd0, 8'h00, 0);

    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end

    // Reset during EXEC of INC rd=1: writeback is dropped.
    do_reset();
    run_instr(1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'h10, 0);
    instr_valid = 1'b1; instr_load = 1'b0; instr_op = 4'd7; instr_fsel = 2'd0;
    instr_rd = 2'd1; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("rstexec_in_exec", instr_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rstexec_rsp_valid", rsp_valid, 0);
    check("rstexec_instr_ready", instr_ready, 1);
    check("rstexec_alu_a", alu_a, 0);
    run_instr(0, 4'd2, 2'd1, 2'd2, 2'd1, 2'd0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
